time_surface_decay: RTL and testbench
=====================================

// Module: time_surface_decay
// PURPOSE
//  Per-cell time-surface store for the gradient-map path. Accepts (x,y) DVS events and stamps each cell with a global tick time.
//  Serves a 2-cycle-latency read port that returns an exponentially decayed 8-bit activity value per cell.
//  Sits directly upstream of the surface flattener, which scans cells row-major through ts_addr/ts_en/ts_val.
// PARAMETERS
//  GRID_SIZE    16   grid dimension; cell addr = y*GRID_SIZE + x
//  NUM_CELLS    256  GRID_SIZE*GRID_SIZE
//  VALUE_BITS   8    decayed output width
//  TS_BITS      16   timestamp / global time counter width
//  DECAY_SHIFT  4    ticks per halving = 2**DECAY_SHIFT
// PORTS
//  clk        in   1                  single clock, all logic posedge
//  rst_n      in   1                  synchronous reset, active-low
//  tick       in   1                  1-cycle pulse, advances global time
//  ev_valid   in   1                  event present
//  ev_x       in   $clog2(GRID_SIZE)  event column
//  ev_y       in   $clog2(GRID_SIZE)  event row
//  ev_ready   out  1                  event accepted when ev_valid & ev_ready
//  init_done  out  1                  high once the post-reset clear has finished
//  ts_en      in   1                  read request
//  ts_addr    in   $clog2(NUM_CELLS)  read cell address
//  ts_val     out  VALUE_BITS         decayed value, 2 cycles after request
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): now=0, ev_ready=0, init_done=0, ts_val=0, read pipe valid bits=0, FSM->S_CLEAR, clr_addr=0.
//  State S_CLEAR: write {vld=0,stamp=0} to cell clr_addr each cycle. After cell NUM_CELLS-1 -> S_RUN (NUM_CELLS cycles).
//  State S_RUN: ev_ready=1, init_done=1. No exit except reset. Reset mid-operation restarts S_CLEAR; all cells read 0 afterwards.
//  Time: now <= now+1 (mod 2**TS_BITS) on each tick. tick counts in every state, including S_CLEAR.
//  Event write: ev_valid&ev_ready at edge N -> cell[y*G+x] <= {vld=1, stamp=now}. Events while ev_ready=0 are dropped, never queued.
//  Storage: storage is dual-port. The write port (clear/event) and the read port are independent.
//  Read pipeline:
//   edge N: ts_en&ts_addr sampled, memory read issued.
//   edge N+1: stage-1 regs hold {vld,stamp} and now.
//   edge N+2: ts_val updated.
//  The pipeline is fully pipelined: one read per cycle, back-to-back.
//  ts_val holds its last value when no request reaches stage 2.
//  Reads issued while in S_CLEAR return 0.
//  Decay (stage 2):
//   dt = (now_s1 - stamp) mod 2**TS_BITS.
//   sh = dt >> DECAY_SHIFT.
//   ts_val = vld ? (sh >= VALUE_BITS ? 0 : (2**VALUE_BITS-1) >> sh) : 0.
//  Decay examples: dt=0 -> 255; dt=16 -> 127; dt=127 -> 1; dt>=128 -> 0.
//  Collision rule: a read and a write to the same cell at the same edge returns the OLD contents. A read one cycle later sees the new stamp.
//  Repeated event to the same cell simply overwrites the stamp (refresh to 255).
//  Wrap-around: dt uses modulo arithmetic. A cell untouched for exactly k*2**TS_BITS ticks aliases to fresh. This is an accepted limitation; no scrubbing.
//  ev_ready is a registered state decode; it does not depend combinationally on ev_valid.
// TESTING
//  T1 reset: rst_n low 2 cycles, release -> init_done rises after exactly 256 cycles; read all 256 cells -> ts_val=0.
//  T2 decay: event (x=3,y=5), now=0. Read addr 83 -> 255 two cycles later. After 16 ticks -> 127. After 32 ticks -> 63. After 128 ticks -> 0.
//  T3 pipeline: 256 back-to-back reads with 3 written cells -> ts_val stream matches model at 2-cycle offset, no bubbles.
//  T4 collision: write cell 10 and read addr 10 at same edge -> old value (0). Read next cycle -> 255.
//  T5 events during S_CLEAR: ev_ready=0, event dropped; cell reads 0 after init.
//  T6 reset mid-run and wrap:
//   Cells written, then rst_n pulse -> all reads 0 after re-clear.
//   Event at now=0xFFF8 then 24 ticks (now wraps to 0x0010) -> dt=24, ts_val=127.

Source files
------------

// File: rtl/time_surface_decay_if.sv
// Bus bundle for the time-surface store: event write channel, global tick and
// the pipelined decayed-value read port.
interface time_surface_decay_if #(
  parameter int GRID_SIZE  = 16,
  parameter int VALUE_BITS = 8
) ();
  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int XY_W      = $clog2(GRID_SIZE);
  localparam int ADDR_W    = $clog2(NUM_CELLS);

  logic                  tick;
  logic                  ev_valid;
  logic [XY_W-1:0]       ev_x;
  logic [XY_W-1:0]       ev_y;
  logic                  ev_ready;
  logic                  init_done;
  logic                  ts_en;
  logic [ADDR_W-1:0]     ts_addr;
  logic [VALUE_BITS-1:0] ts_val;

  modport master (
    output tick, ev_valid, ev_x, ev_y, ts_en, ts_addr,
    input  ev_ready, init_done, ts_val
  );

  modport slave (
    input  tick, ev_valid, ev_x, ev_y, ts_en, ts_addr,
    output ev_ready, init_done, ts_val
  );
endinterface

// File: rtl/time_surface_decay.sv
// Per-cell time-surface store: stamps cells with the global tick time on DVS
// events and serves a 2-cycle read port returning an exponentially decayed value.
module time_surface_decay #(
  parameter int GRID_SIZE   = 16,
  parameter int NUM_CELLS   = GRID_SIZE * GRID_SIZE,
  parameter int VALUE_BITS  = 8,
  parameter int TS_BITS     = 16,
  parameter int DECAY_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  time_surface_decay_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_CELLS);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       clr_addr;
  logic [TS_BITS-1:0]      now;
  logic                    ev_ready, init_done, clearing;

  logic [TS_BITS:0]        mem [NUM_CELLS];
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [TS_BITS:0]        wr_data;

  logic                    vld_p0, clr_p0;
  logic [TS_BITS:0]        cell_p0;
  logic                    vld_p1, clr_p1;
  logic [TS_BITS:0]        cell_p1;
  logic [TS_BITS-1:0]      now_p1;
  logic [VALUE_BITS-1:0]   ts_val;

  function automatic logic [VALUE_BITS-1:0] decay(input logic vld,
                                                  input logic [TS_BITS-1:0] dt);
    logic [TS_BITS-1:0] sh;
    sh = dt >> DECAY_SHIFT;
    if (!vld || sh >= TS_BITS'(VALUE_BITS)) decay = '0;
    else decay = {VALUE_BITS{1'b1}} >> sh;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_addr == ADDR_W'(NUM_CELLS - 1)) state_d = S_RUN;
  end

  always_comb begin
    ev_ready  = 1'b0;
    init_done = 1'b0;
    clearing  = 1'b1;
    if (state_q == S_RUN) begin
      ev_ready  = 1'b1;
      init_done = 1'b1;
      clearing  = 1'b0;
    end
  end

  // Global time keeps running through the clear phase.
  always_ff @(posedge clk) begin
    if (!rst_n) now <= '0;
    else if (bus.tick) now <= now + 1'b1;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = '0;
    if (clearing) begin
      wr_en = 1'b1;
    end else if (bus.ev_valid && ev_ready) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(bus.ev_y) * ADDR_W'(GRID_SIZE) + ADDR_W'(bus.ev_x);
      wr_data = {1'b1, now};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage 0: memory read; a same-edge write to the cell is not yet visible.
  always_ff @(posedge clk) begin
    cell_p0 <= mem[bus.ts_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      clr_p0 <= 1'b0;
    end else begin
      vld_p0 <= bus.ts_en;
      clr_p0 <= clearing;
    end
  end

  // Stage 1: hold cell contents alongside the time they are judged against.
  always_ff @(posedge clk) begin
    cell_p1 <= cell_p0;
    now_p1  <= now;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      clr_p1 <= clr_p0;
    end
  end

  // Stage 2: decayed value; held when no request arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) ts_val <= '0;
    else if (vld_p1) begin
      if (clr_p1) ts_val <= '0;
      else ts_val <= decay(cell_p1[TS_BITS], now_p1 - cell_p1[TS_BITS-1:0]);
    end
  end

  assign bus.ev_ready  = ev_ready;
  assign bus.init_done = init_done;
  assign bus.ts_val    = ts_val;
endmodule

// File: tb/tb_time_surface_decay.sv
// Directed bench for time_surface_decay: stimulus pushes expected read values
// into a scoreboard queue, an independent monitor compares them as they emerge.
module tb_time_surface_decay;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] exp;
    int         addr;
  } exp_t;
  exp_t sbq[$];

  time_surface_decay_if bus ();

  time_surface_decay dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a request sampled at edge N is compared right after edge N+2.
  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      r2 = r1;
      r1 = r0;
      r0 = bus.ts_en && rst_n;
      if (r2) begin
        #1;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got %0d with no pending request", bus.ts_val);
        end else begin
          e = sbq.pop_front();
          if (bus.ts_val !== e.exp) begin
            errors++;
            $display("FAIL read_addr%0d: got %0d expected %0d", e.addr, bus.ts_val, e.exp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int addr, input int exp);
    exp_t e;
    bus.ts_en   = 1'b1;
    bus.ts_addr = 8'(addr);
    e.exp  = 8'(exp);
    e.addr = addr;
    sbq.push_back(e);
    @(negedge clk);
    bus.ts_en = 1'b0;
  endtask

  task automatic event_xy(input int x, input int y);
    bus.ev_valid = 1'b1;
    bus.ev_x     = 4'(x);
    bus.ev_y     = 4'(y);
    @(negedge clk);
    bus.ev_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d reads pending, expected 0", sbq.size());
      sbq.delete();
    end
    idle(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    check("reset_ev_ready", int'(bus.ev_ready), 0);
    check("reset_init_done", int'(bus.init_done), 0);
    check("reset_ts_val", int'(bus.ts_val), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!bus.init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.init_done) check("init_timeout", 0, 1);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 256; a++) begin
      bus.ts_en   = 1'b1;
      bus.ts_addr = 8'(a);
      sbq.push_back('{exp: 8'd0, addr: a});
      @(negedge clk);
    end
    bus.ts_en = 1'b0;
    drain();
  endtask

  initial begin
    int cnt;
    int exp;
    bus.tick = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_x = '0;
    bus.ev_y = '0;
    bus.ts_en = 1'b0;
    bus.ts_addr = '0;
    idle(1);

    // T1: init_done rises exactly 256 cycles after reset release
    do_reset();
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.init_done) break;
    end
    check("init_cycles", cnt, 256);
    check("run_ev_ready", int'(bus.ev_ready), 1);
    @(negedge clk);

    // T5: events during clear are dropped, reads during clear return 0
    do_reset();
    check("clear_ev_ready", int'(bus.ev_ready), 0);
    event_xy(1, 2);
    issue(0, 0);
    drain();
    wait_init();
    issue(33, 0);
    drain();
    read_all_zero();

    // T2: decay of a single cell
    event_xy(3, 5);
    issue(83, 255); drain();
    ticks(16); issue(83, 127); drain();
    ticks(16); issue(83, 63); drain();
    ticks(96); issue(83, 0); drain();
    event_xy(8, 12);
    ticks(127); issue(200, 1); drain();
    ticks(1); issue(200, 0); drain();
    event_xy(3, 5);
    issue(83, 255); drain();

    // T4: same-edge write/read returns old contents, next cycle the new one
    bus.ev_valid = 1'b1;
    bus.ev_x = 4'd10;
    bus.ev_y = 4'd0;
    bus.ts_en = 1'b1;
    bus.ts_addr = 8'd10;
    sbq.push_back('{exp: 8'd0, addr: 10});
    @(negedge clk);
    bus.ev_valid = 1'b0;
    issue(10, 255);
    drain();

    // T6a: reset mid-run clears everything
    do_reset();
    wait_init();
    read_all_zero();

    // T3: back-to-back stream over three stamped cells (now=32 at read time)
    event_xy(5, 0);
    ticks(16);
    event_xy(4, 6);
    ticks(16);
    event_xy(15, 15);
    for (int a = 0; a < 256; a++) begin
      exp = (a == 5) ? 63 : (a == 100) ? 127 : (a == 255) ? 255 : 0;
      bus.ts_en   = 1'b1;
      bus.ts_addr = 8'(a);
      sbq.push_back('{exp: 8'(exp), addr: a});
      @(negedge clk);
    end
    bus.ts_en = 1'b0;
    drain();
    idle(3);
    check("hold_ts_val", int'(bus.ts_val), 255);

    // T6b: stamp at 0xFFF8, time wraps to 0x0010
    ticks(16'hFFF8 - 32);
    event_xy(7, 0);
    ticks(24);
    issue(7, 127);
    issue(255, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
